// File: rtl/csr_pkg.sv
// csr_pkg: CSR addresses, access encoding, bit indices, cause codes and mstatus fields
package csr_pkg;
  localparam logic [11:0] CSR_MSTATUS   = 12'h300;
  localparam logic [11:0] CSR_MISA      = 12'h301;
  localparam logic [11:0] CSR_MIE       = 12'h304;
  localparam logic [11:0] CSR_MTVEC     = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
  localparam logic [11:0] CSR_MEPC      = 12'h341;
  localparam logic [11:0] CSR_MCAUSE    = 12'h342;
  localparam logic [11:0] CSR_MTVAL     = 12'h343;
  localparam logic [11:0] CSR_MIP       = 12'h344;
  localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
  localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
  localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
  localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
  localparam logic [11:0] CSR_MVENDORID = 12'hF11;
  localparam logic [11:0] CSR_MARCHID   = 12'hF12;
  localparam logic [11:0] CSR_MIMPID    = 12'hF13;
  localparam logic [11:0] CSR_MHARTID   = 12'hF14;
  typedef enum logic [1:0] {
    CSR_READ_ONLY = 2'b00,
    CSR_WRITE     = 2'b01,
    CSR_SET       = 2'b10,
    CSR_CLEAR     = 2'b11
  } csr_access_e;
  localparam int MSTATUS_MIE  = 3;
  localparam int MSTATUS_MPIE = 7;
  localparam int MSTATUS_MPP  = 11;
  localparam int MIE_MSIE     = 3;
  localparam int MIE_MTIE     = 7;
  localparam int MIE_MEIE     = 11;
  localparam int MIP_MSIP     = 3;
  localparam int MIP_MTIP     = 7;
  localparam int MIP_MEIP     = 11;
  localparam int CAUSE_ILLEGAL_INSTR = 2;
  localparam int CAUSE_BREAKPOINT    = 3;
  localparam int CAUSE_ECALL_M       = 11;
  localparam int CAUSE_IRQ_SOFT      = 3;
  localparam int CAUSE_IRQ_TIMER     = 7;
  localparam int CAUSE_IRQ_EXT       = 11;
  typedef struct packed {
    logic mpie;
    logic mie;
  } mstatus_t;
  function automatic logic [63:0] csr_wdata(input logic [1:0] t, input logic [63:0] cur, input logic [63:0] op);
    return t == CSR_SET ? cur | op : t == CSR_CLEAR ? cur & ~op : op;
  endfunction
endpackage

// File: rtl/csr_counter.sv
// csr_counter: free-running counter whose low/high halves can be overwritten from an XLEN bus
module csr_counter #(
  parameter int CNT_WIDTH = 64,
  parameter int XLEN      = 32
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 inc,
  input  logic                 wr_lo,
  input  logic                 wr_hi,
  input  logic [XLEN-1:0]      data,
  output logic [CNT_WIDTH-1:0] value
);
  localparam int LW = CNT_WIDTH > XLEN ? XLEN : CNT_WIDTH;
  localparam logic [CNT_WIDTH-1:0] LO_MASK = (CNT_WIDTH'(1) << LW) - CNT_WIDTH'(1);
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d, wide;
  always_comb begin
    wide  = CNT_WIDTH'(data);
    cnt_d = wr_lo ? (cnt_q & ~LO_MASK) | (wide & LO_MASK)
          : wr_hi ? (cnt_q & LO_MASK) | ((wide << LW) & ~LO_MASK)
          : cnt_q + CNT_WIDTH'(inc);
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  assign value = cnt_q;
endmodule

// File: rtl/csr_file.sv
// csr_file: machine-mode CSRs, counters, trap entry/mret sequencing and interrupt pending
module csr_file
  import csr_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int HART_ID   = 0,
  parameter int CNT_WIDTH = 64
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [11:0]     number,
  input  logic [1:0]      access_type,
  input  logic [XLEN-1:0] in,
  output logic [XLEN-1:0] out,
  output logic            illegal,
  input  logic            retire,
  input  logic            trap_valid,
  input  logic [XLEN-1:0] trap_cause,
  input  logic [XLEN-1:0] trap_pc,
  input  logic [XLEN-1:0] trap_tval,
  input  logic            mret,
  output logic [XLEN-1:0] trap_target,
  output logic [XLEN-1:0] epc,
  input  logic            irq_ext,
  input  logic            irq_timer,
  input  logic            irq_soft,
  output logic            irq_pending
);
  localparam bit IS_RV32 = XLEN == 32;
  localparam logic [XLEN-1:0] MIE_MASK = XLEN'(1) << MIE_MSIE | XLEN'(1) << MIE_MTIE | XLEN'(1) << MIE_MEIE;
  localparam logic [XLEN-1:0] MISA_VAL = XLEN'(XLEN == 64 ? 2 : 1) << (XLEN - 2) | XLEN'(1) << 8;
  mstatus_t        mstatus_q, mstatus_d;
  logic [XLEN-1:0] mtvec_q, mtvec_d, mie_q, mie_d, mscratch_q, mscratch_d;
  logic [XLEN-1:0] mepc_q, mepc_d, mcause_q, mcause_d, mtval_q, mtval_d;
  logic [XLEN-1:0] mstatus_rd, mip_rd, wdata;
  logic [CNT_WIDTH-1:0] mcycle, minstret;
  logic impl, we;
  assign mstatus_rd = XLEN'(2'b11) << MSTATUS_MPP | XLEN'(mstatus_q.mpie) << MSTATUS_MPIE | XLEN'(mstatus_q.mie) << MSTATUS_MIE;
  assign mip_rd     = XLEN'(irq_soft) << MIP_MSIP | XLEN'(irq_timer) << MIP_MTIP | XLEN'(irq_ext) << MIP_MEIP;
  always_comb begin
    impl = 1'b1;
    out  = '0;
    case (number)
      CSR_MISA:      out = MISA_VAL;
      CSR_MVENDORID, CSR_MARCHID, CSR_MIMPID: out = '0;
      CSR_MHARTID:   out = XLEN'(HART_ID);
      CSR_MSTATUS:   out = mstatus_rd;
      CSR_MTVEC:     out = mtvec_q;
      CSR_MIE:       out = mie_q;
      CSR_MIP:       out = mip_rd;
      CSR_MSCRATCH:  out = mscratch_q;
      CSR_MEPC:      out = mepc_q;
      CSR_MCAUSE:    out = mcause_q;
      CSR_MTVAL:     out = mtval_q;
      CSR_MCYCLE:    out = XLEN'(mcycle);
      CSR_MINSTRET:  out = XLEN'(minstret);
      CSR_MCYCLEH: begin
        impl = IS_RV32;
        out  = IS_RV32 ? XLEN'(mcycle >> XLEN) : '0;
      end
      CSR_MINSTRETH: begin
        impl = IS_RV32;
        out  = IS_RV32 ? XLEN'(minstret >> XLEN) : '0;
      end
      default:       impl = 1'b0;
    endcase
  end
  assign illegal = !impl || (number[11:10] == 2'b11 && access_type != CSR_READ_ONLY);
  assign we      = access_type != CSR_READ_ONLY && !illegal && !trap_valid && !mret;
  assign wdata   = XLEN'(csr_wdata(access_type, 64'(out), 64'(in)));
  always_comb begin
    mstatus_d  = mstatus_q;
    mtvec_d    = mtvec_q;
    mie_d      = mie_q;
    mscratch_d = mscratch_q;
    mepc_d     = mepc_q;
    mcause_d   = mcause_q;
    mtval_d    = mtval_q;
    if (trap_valid) begin
      mepc_d    = trap_pc & ~XLEN'(3);
      mcause_d  = trap_cause;
      mtval_d   = trap_tval;
      mstatus_d = '{mpie: mstatus_q.mie, mie: 1'b0};
    end else if (mret) begin
      mstatus_d = '{mpie: 1'b1, mie: mstatus_q.mpie};
    end else if (we) begin
      case (number)
        CSR_MSTATUS:  mstatus_d  = '{mpie: wdata[MSTATUS_MPIE], mie: wdata[MSTATUS_MIE]};
        CSR_MTVEC:    mtvec_d    = {wdata[XLEN-1:2], wdata[1] ? 2'b00 : wdata[1:0]};
        CSR_MIE:      mie_d      = wdata & MIE_MASK;
        CSR_MSCRATCH: mscratch_d = wdata;
        CSR_MEPC:     mepc_d     = wdata & ~XLEN'(3);
        CSR_MCAUSE:   mcause_d   = wdata;
        CSR_MTVAL:    mtval_d    = wdata;
        default:      ;
      endcase
    end
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      mstatus_q  <= '0;
      mtvec_q    <= '0;
      mie_q      <= '0;
      mscratch_q <= '0;
      mepc_q     <= '0;
      mcause_q   <= '0;
      mtval_q    <= '0;
    end else begin
      mstatus_q  <= mstatus_d;
      mtvec_q    <= mtvec_d;
      mie_q      <= mie_d;
      mscratch_q <= mscratch_d;
      mepc_q     <= mepc_d;
      mcause_q   <= mcause_d;
      mtval_q    <= mtval_d;
    end
  csr_counter #(.CNT_WIDTH(CNT_WIDTH), .XLEN(XLEN)) u_mcycle (
    .clk(clk), .reset_n(reset_n), .inc(1'b1),
    .wr_lo(we && number == CSR_MCYCLE), .wr_hi(we && number == CSR_MCYCLEH),
    .data(wdata), .value(mcycle)
  );
  csr_counter #(.CNT_WIDTH(CNT_WIDTH), .XLEN(XLEN)) u_minstret (
    .clk(clk), .reset_n(reset_n), .inc(retire),
    .wr_lo(we && number == CSR_MINSTRET), .wr_hi(we && number == CSR_MINSTRETH),
    .data(wdata), .value(minstret)
  );
  // vectoring applies only to interrupts; exceptions always enter at BASE
  assign trap_target = {mtvec_q[XLEN-1:2], 2'b00} +
                       (mtvec_q[1:0] == 2'b01 && trap_cause[XLEN-1] ? {trap_cause[XLEN-3:0], 2'b00} : '0);
  assign epc         = mepc_q;
  assign irq_pending = mstatus_q.mie & |(mie_q & mip_rd);
endmodule

// File: tb/tb_csr_file.sv
// tb_csr_file: directed vectors with hand-computed expectations for csr_file at XLEN=32
module tb_csr_file;
  import csr_pkg::*;
  logic        clk = 1'b0;
  logic        reset_n;
  logic [11:0] number;
  logic [1:0]  access_type;
  logic [31:0] din, out, trap_cause, trap_pc, trap_tval, trap_target, epc;
  logic        illegal, retire, trap_valid, mret, irq_ext, irq_timer, irq_soft, irq_pending;
  int n_chk = 0, n_pass = 0;

  always #5 clk = ~clk;

  csr_file dut (
    .clk(clk), .reset_n(reset_n), .number(number), .access_type(access_type), .in(din),
    .out(out), .illegal(illegal), .retire(retire), .trap_valid(trap_valid),
    .trap_cause(trap_cause), .trap_pc(trap_pc), .trap_tval(trap_tval), .mret(mret),
    .trap_target(trap_target), .epc(epc), .irq_ext(irq_ext), .irq_timer(irq_timer),
    .irq_soft(irq_soft), .irq_pending(irq_pending)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %h want %h", tag, obs, exp);
  endtask

  task automatic rd(input logic [11:0] n, input logic [31:0] exp, input string tag);
    number = n;
    #1;
    check(tag, out, exp);
  endtask

  task automatic wr(input logic [11:0] n, input logic [1:0] t, input logic [31:0] d);
    number = n;
    access_type = t;
    din = d;
    @(posedge clk);
    #1;
    access_type = CSR_READ_ONLY;
    din = '0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset_n = 1'b0; number = CSR_MEPC; access_type = CSR_READ_ONLY; din = '0;
    retire = 1'b0; trap_valid = 1'b0; trap_cause = '0; trap_pc = '0; trap_tval = '0;
    mret = 1'b0; irq_ext = 1'b0; irq_timer = 1'b0; irq_soft = 1'b0;
    #1;
    check("rst_epc", epc, 0);
    check("rst_irq_pending", irq_pending, 0);
    rd(CSR_MSTATUS, 32'h0000_1800, "rst_mstatus");
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    rd(CSR_MCYCLE, 0, "mcycle_first");
    rd(CSR_MCYCLEH, 0, "mcycleh_first");
    step();
    rd(CSR_MCYCLE, 1, "mcycle_second");

    number = CSR_MSCRATCH; access_type = CSR_WRITE; din = 32'hDEAD_BEEF;
    #1 check("mscratch_old_on_write", out, 0);
    step();
    access_type = CSR_READ_ONLY;
    rd(CSR_MSCRATCH, 32'hDEAD_BEEF, "mscratch_write");
    wr(CSR_MSCRATCH, CSR_SET, 32'h10);
    rd(CSR_MSCRATCH, 32'hDEAD_BEFF, "mscratch_set");
    wr(CSR_MSCRATCH, CSR_CLEAR, 32'hF);
    rd(CSR_MSCRATCH, 32'hDEAD_BEF0, "mscratch_clear");
    wr(CSR_MTVEC, CSR_WRITE, 32'h103);
    rd(CSR_MTVEC, 32'h100, "mtvec_warl");

    number = CSR_MHARTID; access_type = CSR_WRITE; din = 32'h5;
    #1 check("mhartid_wr_illegal", illegal, 1);
    step();
    access_type = CSR_READ_ONLY;
    rd(CSR_MHARTID, 0, "mhartid_unchanged");
    check("mhartid_rd_legal", illegal, 0);
    rd(12'h7C0, 0, "unimpl_out");
    check("unimpl_illegal", illegal, 1);
    rd(CSR_MISA, 32'h4000_0100, "misa");
    check("misa_legal", illegal, 0);
    number = CSR_MIP; access_type = CSR_WRITE; din = 32'hFFFF_FFFF;
    #1 check("mip_wr_legal", illegal, 0);
    step();
    access_type = CSR_READ_ONLY;
    rd(CSR_MIP, 0, "mip_wr_ignored");

    wr(CSR_MSTATUS, CSR_SET, 32'h8);
    rd(CSR_MSTATUS, 32'h0000_1808, "mstatus_mie_set");
    trap_valid = 1'b1; trap_pc = 32'h8000_0046; trap_cause = CAUSE_ILLEGAL_INSTR; trap_tval = 32'h1234;
    #1 check("trap_target_direct", trap_target, 32'h100);
    step();
    trap_valid = 1'b0;
    rd(CSR_MEPC, 32'h8000_0044, "trap_mepc");
    rd(CSR_MCAUSE, 2, "trap_mcause");
    rd(CSR_MTVAL, 32'h1234, "trap_mtval");
    rd(CSR_MSTATUS, 32'h0000_1880, "trap_mstatus");
    mret = 1'b1;
    step();
    mret = 1'b0;
    rd(CSR_MSTATUS, 32'h0000_1888, "mret_mstatus");
    check("mret_epc", epc, 32'h8000_0044);

    wr(CSR_MTVEC, CSR_WRITE, 32'h1001);
    wr(CSR_MIE, CSR_WRITE, 32'hFFFF_FFFF);
    rd(CSR_MIE, 32'h888, "mie_mask");
    wr(CSR_MIE, CSR_CLEAR, 32'h808);
    check("irq_pending_idle", irq_pending, 0);
    irq_timer = 1'b1;
    rd(CSR_MIP, 32'h80, "mip_timer");
    check("irq_pending_timer", irq_pending, 1);
    trap_cause = CAUSE_ILLEGAL_INSTR;
    #1 check("trap_target_exc_vec_mode", trap_target, 32'h1000);
    trap_valid = 1'b1; trap_cause = 32'h8000_0000 | CAUSE_IRQ_TIMER; trap_pc = 32'h400;
    #1 check("trap_target_vectored", trap_target, 32'h101C);
    step();
    trap_valid = 1'b0;
    check("irq_masked_after_trap", irq_pending, 0);
    irq_timer = 1'b0;

    wr(CSR_MCYCLE, CSR_WRITE, 32'hFFFF_FFFF);
    rd(CSR_MCYCLE, 32'hFFFF_FFFF, "mcycle_written");
    rd(CSR_MCYCLEH, 0, "mcycleh_no_carry");
    step();
    rd(CSR_MCYCLEH, 1, "mcycleh_carry");
    rd(CSR_MCYCLE, 0, "mcycle_wrap");
    rd(CSR_MINSTRET, 0, "minstret_idle");
    retire = 1'b1;
    repeat (5) @(posedge clk);
    #1 retire = 1'b0;
    rd(CSR_MINSTRET, 5, "minstret_5");

    number = CSR_MEPC; access_type = CSR_WRITE; din = 32'h5555_5555;
    trap_valid = 1'b1; trap_pc = 32'h2000; trap_cause = CAUSE_BREAKPOINT;
    step();
    trap_valid = 1'b0; access_type = CSR_READ_ONLY;
    rd(CSR_MEPC, 32'h2000, "collision_mepc");

    trap_valid = 1'b1; trap_pc = 32'h3000;
    #2 reset_n = 1'b0;
    rd(CSR_MSCRATCH, 0, "async_rst_mscratch");
    rd(CSR_MEPC, 0, "async_rst_mepc");
    rd(CSR_MTVEC, 0, "async_rst_mtvec");
    rd(CSR_MIE, 0, "async_rst_mie");
    rd(CSR_MSTATUS, 32'h0000_1800, "async_rst_mstatus");
    rd(CSR_MCYCLE, 0, "async_rst_mcycle");
    check("async_rst_epc", epc, 0);
    trap_valid = 1'b0;
    step();
    reset_n = 1'b1;
    rd(CSR_MEPC, 0, "trap_lost_in_reset");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
